// File: rtl/dram_ctrl_pkg.sv
// Shared types and default timing for the DRAM command sequencer.
// Holds the FSM state encoding, the default timing and geometry, and the derived widths.
package dram_ctrl_pkg;

    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_DATA_WIDTH   = 1;

    localparam int DEF_T_RP   = 2;
    localparam int DEF_T_RCD  = 2;
    localparam int DEF_T_CL   = 2;
    localparam int DEF_T_REFI = 256;
    localparam int DEF_T_RFC  = 4;

    // Phase counter width; every timing value must fit in it.
    localparam int CNT_W = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_BANK_W = clog2_min1(DEF_NUM_OF_BANKS);
    localparam int DEF_ROW_W  = clog2_min1(DEF_NUM_OF_ROWS);
    localparam int DEF_COL_W  = clog2_min1(DEF_NUM_OF_COLS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_ACTIVATE  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_RESP      = 3'd5,
        ST_REFRESH   = 3'd6
    } state_e;

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker.
// Classifies a bank/row lookup as hit, conflict or closed.
module dram_open_row_table
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int BANK_W       = DEF_BANK_W,
    parameter int ROW_W        = DEF_ROW_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [BANK_W-1:0] lookup_bank,
    input  logic [ROW_W-1:0]  lookup_row,
    output logic              hit,
    output logic              conflict,
    output logic              closed,
    input  logic              set_en,
    input  logic [BANK_W-1:0] set_bank,
    input  logic [ROW_W-1:0]  set_row,
    input  logic              clr_en,
    input  logic [BANK_W-1:0] clr_bank,
    input  logic              clr_all
);

    logic [NUM_OF_BANKS-1:0] valid_q, valid_d;
    logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];
    logic [ROW_W-1:0]        row_d [NUM_OF_BANKS];

    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        // A refresh closes everything and overrides any single-bank update.
        if (clr_all) begin
            valid_d = '0;
        end else begin
            if (clr_en) valid_d[clr_bank] = 1'b0;
            if (set_en) begin
                valid_d[set_bank] = 1'b1;
                row_d[set_bank]   = set_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) row_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        closed   = !valid_q[lookup_bank];
        hit      = valid_q[lookup_bank] && (row_q[lookup_bank] == lookup_row);
        conflict = valid_q[lookup_bank] && (row_q[lookup_bank] != lookup_row);
    end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Single-requester DRAM command sequencer: open-row tracking, tRP/tRCD/tCL timing,
// periodic refresh, one response per accepted request.
module dram_cmd_sequencer
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CL         = DEF_T_CL,
    parameter int T_REFI       = DEF_T_REFI,
    parameter int T_RFC        = DEF_T_RFC,
    localparam int BANK_W      = clog2_min1(NUM_OF_BANKS),
    localparam int ROW_W       = clog2_min1(NUM_OF_ROWS),
    localparam int COL_W       = clog2_min1(NUM_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BANK_W-1:0]     req_bank,
    input  logic [ROW_W-1:0]      req_row,
    input  logic [COL_W-1:0]      req_col,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  dram_bank_rw,
    output logic                  dram_buffer_rw,
    output logic [BANK_W-1:0]     dram_bank_id,
    output logic [ROW_W-1:0]      dram_rowid,
    output logic [COL_W-1:0]      dram_colid,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    output logic                  dram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  refresh_busy,
    output logic [2:0]            dbg_state
);

    localparam int REF_W = clog2_min1(T_REFI);
    localparam logic [REF_W-1:0] REFI_LAST = REF_W'(T_REFI - 1);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_valid may be held across cycles, and the fields are sampled only on that edge.

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic                  pending_q, pending_d;
    logic                  lat_write_q, lat_write_d;
    logic [BANK_W-1:0]     lat_bank_q, lat_bank_d;
    logic [ROW_W-1:0]      lat_row_q, lat_row_d;
    logic [COL_W-1:0]      lat_col_q, lat_col_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  bank_rw_q, bank_rw_d;
    logic                  buffer_rw_q, buffer_rw_d;
    logic                  refresh_busy_q, refresh_busy_d;

    logic tbl_hit, tbl_conflict, tbl_closed;
    logic tbl_set, tbl_clr, tbl_clr_all;

    dram_open_row_table #(
        .NUM_OF_BANKS(NUM_OF_BANKS),
        .BANK_W      (BANK_W),
        .ROW_W       (ROW_W)
    ) u_open_rows (
        .clk        (clk),
        .rst_b      (rst_b),
        .lookup_bank(req_bank),
        .lookup_row (req_row),
        .hit        (tbl_hit),
        .conflict   (tbl_conflict),
        .closed     (tbl_closed),
        .set_en     (tbl_set),
        .set_bank   (lat_bank_q),
        .set_row    (lat_row_q),
        .clr_en     (tbl_clr),
        .clr_bank   (lat_bank_q),
        .clr_all    (tbl_clr_all)
    );

    assign req_ready = (state_q == ST_IDLE) && !pending_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        lat_write_d  = lat_write_q;
        lat_bank_d   = lat_bank_q;
        lat_row_d    = lat_row_q;
        lat_col_d    = lat_col_q;
        lat_wdata_d  = lat_wdata_q;
        resp_rdata_d = '0;
        tbl_set      = 1'b0;
        tbl_clr      = 1'b0;
        tbl_clr_all  = 1'b0;
        ref_cnt_d    = (ref_cnt_q == REFI_LAST) ? '0 : ref_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d     = ST_REFRESH;
                    cnt_d       = CNT_W'(T_RFC - 1);
                    pending_d   = 1'b0;
                    tbl_clr_all = 1'b1;
                end else if (req_valid) begin
                    lat_write_d = req_write;
                    lat_bank_d  = req_bank;
                    lat_row_d   = req_row;
                    lat_col_d   = req_col;
                    lat_wdata_d = req_wdata;
                    if (tbl_hit) begin
                        state_d = req_write ? ST_WRITE : ST_READ;
                        cnt_d   = CNT_W'(T_CL - 1);
                    end else if (tbl_closed) begin
                        state_d = ST_ACTIVATE;
                        cnt_d   = CNT_W'(T_RCD - 1);
                    end else if (tbl_conflict) begin
                        state_d = ST_PRECHARGE;
                        cnt_d   = CNT_W'(T_RP - 1);
                    end
                end
            end
            ST_PRECHARGE: begin
                if (cnt_q == '0) begin
                    tbl_clr = 1'b1;
                    state_d = ST_ACTIVATE;
                    cnt_d   = CNT_W'(T_RCD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVATE: begin
                if (cnt_q == '0) begin
                    tbl_set = 1'b1;
                    state_d = lat_write_q ? ST_WRITE : ST_READ;
                    cnt_d   = CNT_W'(T_CL - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_READ: begin
                // Array data is captured on the edge that ends the last strobe cycle.
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = dram_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_REFRESH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap landing on the refresh-entry edge must not be lost.
        if (ref_cnt_q == REFI_LAST) pending_d = 1'b1;

        bank_rw_d      = (state_d == ST_WRITE);
        buffer_rw_d    = (state_d == ST_READ);
        resp_valid_d   = (state_d == ST_RESP);
        refresh_busy_d = (state_d == ST_REFRESH);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ref_cnt_q      <= '0;
            pending_q      <= 1'b0;
            lat_write_q    <= 1'b0;
            lat_bank_q     <= '0;
            lat_row_q      <= '0;
            lat_col_q      <= '0;
            lat_wdata_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            bank_rw_q      <= 1'b0;
            buffer_rw_q    <= 1'b0;
            refresh_busy_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ref_cnt_q      <= ref_cnt_d;
            pending_q      <= pending_d;
            lat_write_q    <= lat_write_d;
            lat_bank_q     <= lat_bank_d;
            lat_row_q      <= lat_row_d;
            lat_col_q      <= lat_col_d;
            lat_wdata_q    <= lat_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            bank_rw_q      <= bank_rw_d;
            buffer_rw_q    <= buffer_rw_d;
            refresh_busy_q <= refresh_busy_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign dram_bank_rw   = bank_rw_q;
    assign dram_wdata_oe  = bank_rw_q;
    assign dram_buffer_rw = buffer_rw_q;
    assign dram_bank_id   = lat_bank_q;
    assign dram_rowid     = lat_row_q;
    assign dram_colid     = lat_col_q;
    assign dram_wdata     = lat_wdata_q;
    assign refresh_busy   = refresh_busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Self-checking bench for dram_cmd_sequencer: directed plan steps, then random traffic,
// all judged against a transaction-level timing model of open rows and refresh.
module tb_dram_cmd_sequencer;

    localparam int T_RP   = 2;
    localparam int T_RCD  = 2;
    localparam int T_CL   = 2;
    localparam int T_REFI = 32;
    localparam int T_RFC  = 4;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [2:0] req_bank = '0;
    logic [6:0] req_row = '0;
    logic [2:0] req_col = '0;
    logic [0:0] req_wdata = '0;
    logic       resp_valid;
    logic [0:0] resp_rdata;
    logic       dram_bank_rw;
    logic       dram_buffer_rw;
    logic [2:0] dram_bank_id;
    logic [6:0] dram_rowid;
    logic [2:0] dram_colid;
    logic [0:0] dram_wdata;
    logic       dram_wdata_oe;
    logic [0:0] dram_rdata = '0;
    logic       refresh_busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dram_cmd_sequencer #(.T_REFI(T_REFI)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .dram_bank_rw(dram_bank_rw), .dram_buffer_rw(dram_buffer_rw),
        .dram_bank_id(dram_bank_id), .dram_rowid(dram_rowid), .dram_colid(dram_colid),
        .dram_wdata(dram_wdata), .dram_wdata_oe(dram_wdata_oe), .dram_rdata(dram_rdata),
        .refresh_busy(refresh_busy), .dbg_state(dbg_state)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int refreshes = 0;
    bit pending = 0;
    bit open_v [8];
    logic [6:0] open_row [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0;
        pending = 0;
        foreach (open_v[i]) open_v[i] = 0;
    endtask

    // Cycle c runs with the refresh counter at c mod T_REFI, so pending appears at multiples of T_REFI.
    task automatic tick(input bit clear_pending);
        @(posedge clk);
        #1;
        cyc++;
        if (clear_pending) pending = 0;
        if (cyc % T_REFI == 0) pending = 1;
    endtask

    task automatic chk_cycle(input string tag, input bit bank_rw, input bit buf_rw,
                             input bit resp, input bit busy, input bit ready);
        chk({tag, ".bank_rw"}, dram_bank_rw, bank_rw);
        chk({tag, ".buffer_rw"}, dram_buffer_rw, buf_rw);
        chk({tag, ".wdata_oe"}, dram_wdata_oe, bank_rw);
        chk({tag, ".resp_valid"}, resp_valid, resp);
        chk({tag, ".refresh_busy"}, refresh_busy, busy);
        chk({tag, ".req_ready"}, req_ready, ready);
    endtask

    task automatic service_refresh();
        chk_cycle("ref_wait", 0, 0, 0, 0, 0);
        tick(1);
        foreach (open_v[i]) open_v[i] = 0;
        for (int i = 0; i < T_RFC; i++) begin
            chk_cycle("refresh", 0, 0, 0, 1, 0);
            tick(0);
        end
        refreshes++;
    endtask

    task automatic idle_step();
        req_valid = 0;
        if (pending) service_refresh();
        else begin
            chk_cycle("idle", 0, 0, 0, 0, 1);
            tick(0);
        end
    endtask

    // abort_at > 0 pulses reset in that cycle after acceptance instead of finishing.
    task automatic do_req(input bit wr, input int bank, input int row, input int col,
                          input bit wd, input bit rd, input int abort_at);
        int guard;
        int n_pre, n_act, n_acc, total;
        bit in_acc;
        req_valid = 1;
        req_write = wr;
        req_bank  = 3'(bank);
        req_row   = 7'(row);
        req_col   = 3'(col);
        req_wdata = wd;
        guard = 0;
        while (pending) begin
            if (guard++ > 4) begin
                chk("accept_timeout", 1, 0);
                req_valid = 0;
                return;
            end
            service_refresh();
        end
        chk("ready_at_accept", req_ready, 1);
        n_pre = (open_v[bank] && open_row[bank] != 7'(row)) ? T_RP : 0;
        n_act = (open_v[bank] && open_row[bank] == 7'(row)) ? 0 : T_RCD;
        n_acc = wr ? 1 : T_CL;
        total = n_pre + n_act + n_acc;
        tick(0);
        req_valid = 0;
        req_write = 1'($urandom);
        req_bank  = 3'($urandom);
        req_row   = 7'($urandom);
        req_col   = 3'($urandom);
        req_wdata = 1'($urandom);
        for (int k = 1; k <= total; k++) begin
            in_acc = (k > n_pre + n_act);
            if (!wr && in_acc) dram_rdata = (k == total) ? rd : 1'($urandom);
            else dram_rdata = 1'($urandom);
            chk_cycle("txn", wr && in_acc, !wr && in_acc, 0, 0, 0);
            if (in_acc) begin
                chk("bank_id", dram_bank_id, 32'(bank));
                chk("rowid", dram_rowid, 32'(row));
                chk("colid", dram_colid, 32'(col));
                if (wr) chk("wdata", dram_wdata, 32'(wd));
            end
            if (k == abort_at) begin
                rst_b = 0;
                #1;
                chk("rst.bank_rw", dram_bank_rw, 0);
                chk("rst.buffer_rw", dram_buffer_rw, 0);
                chk("rst.resp_valid", resp_valid, 0);
                chk("rst.refresh_busy", refresh_busy, 0);
                chk("rst.addr", {dram_bank_id, dram_rowid, dram_colid}, 0);
                #1;
                rst_b = 1;
                model_reset();
                return;
            end
            tick(0);
        end
        chk_cycle("resp", 0, 0, 1, 0, 0);
        chk("resp_rdata", resp_rdata, wr ? 0 : 32'(rd));
        open_v[bank]   = 1;
        open_row[bank] = 7'(row);
        tick(0);
    endtask

    initial begin
        int ref_before;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.bank_rw", dram_bank_rw, 0);
        chk("reset.buffer_rw", dram_buffer_rw, 0);
        chk("reset.wdata_oe", dram_wdata_oe, 0);
        chk("reset.resp", {resp_valid, resp_rdata}, 0);
        chk("reset.refresh_busy", refresh_busy, 0);
        chk("reset.addr", {dram_bank_id, dram_rowid, dram_colid, dram_wdata}, 0);
        rst_b = 1;
        model_reset();
        repeat (10) idle_step();

        do_req(1, 3, 5, 2, 1, 0, 0);
        do_req(0, 3, 5, 2, 0, 1, 0);
        do_req(0, 3, 9, 0, 0, 0, 0);
        do_req(0, 3, 9, 0, 0, 1, 0);

        // Requests held back to back until a refresh has been serviced.
        ref_before = refreshes;
        for (int i = 0; i < 20 && refreshes == ref_before; i++)
            do_req(1'($urandom), 5, $urandom_range(0, 1), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom), 0);
        chk("refresh_seen", 32'(refreshes - ref_before), 1);
        do_req(0, 3, 9, 1, 0, 1, 0);

        do_req(0, 3, 9, 4, 0, 1, 2);
        repeat (6) idle_step();
        do_req(0, 3, 9, 4, 0, 0, 0);

        for (int i = 0; i < 120; i++) begin
            do_req(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 7), 1'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(0, 2)) idle_step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
- Single-requester command sequencer sitting between host logic and the banked DRAM array model (bank/buffer strobes, bank/row/col address, 1-bit data).
- Tracks the open row per bank and enforces precharge/activate/CAS timing.
- Issues periodic refresh.
- Turns each accepted read or write request into a correctly timed strobe sequence and returns one response per request.

Parameters:
- NUM_OF_BANKS, 8, number of banks
- NUM_OF_ROWS, 128, rows per bank
- NUM_OF_COLS, 8, columns per row
- DATA_WIDTH, 1, data bits per cell
- T_RP, 2, precharge cycles (min 1)
- T_RCD, 2, activate-to-access cycles (min 1)
- T_CL, 2, read strobe cycles before data sampled (min 1)
- T_REFI, 256, refresh interval in cycles
- T_RFC, 4, refresh busy cycles (min 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_bank  in  $clog2(NUM_OF_BANKS)  bank address
- req_row  in  $clog2(NUM_OF_ROWS)  row address
- req_col  in  $clog2(NUM_OF_COLS)  column address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid on reads, 0 on writes
- dram_bank_rw  out  1  array write strobe
- dram_buffer_rw  out  1  array-to-buffer read strobe; array drives data while high
- dram_bank_id  out  $clog2(NUM_OF_BANKS)  bank select
- dram_rowid  out  $clog2(NUM_OF_ROWS)  row select
- dram_colid  out  $clog2(NUM_OF_COLS)  column select
- dram_wdata  out  DATA_WIDTH  write data to array
- dram_wdata_oe  out  1  tristate enable for dram_wdata; equals dram_bank_rw
- dram_rdata  in  DATA_WIDTH  data from array
- refresh_busy  out  1  high during REFRESH state

Behaviour:
- Reset (async, rst_b low):
  - All outputs 0; state IDLE.
  - Open-row table cleared (all banks closed); refresh counter 0; pending cleared.
  - Any in-flight request is dropped and gets no response.
- States: IDLE, PRECHARGE, ACTIVATE, WRITE, READ, RESP, REFRESH.
- req_ready = (state==IDLE) && !refresh_pending. It is combinational and the only combinational output.
- On acceptance, latch write/bank/row/col/wdata. Registered outputs then drive the latched address from the next cycle until RESP.
- Path selection at acceptance:
  - Hit (bank open, same row): go to WRITE or READ.
  - Closed bank: go to ACTIVATE.
  - Conflict (bank open, other row): go to PRECHARGE.
- PRECHARGE: T_RP cycles, strobes low, then the table entry is cleared and the state moves to ACTIVATE.
- ACTIVATE: T_RCD cycles, strobes low. On exit the table records the row as open.
- WRITE: exactly one cycle with dram_bank_rw=1, dram_wdata_oe=1, dram_wdata=latched data, then RESP.
- READ: dram_buffer_rw=1 for T_CL consecutive cycles. dram_rdata is sampled on the last of these edges, then RESP.
- RESP: one cycle, resp_valid=1 (resp_rdata = sampled data for reads), then IDLE.
- Latency, with request accepted in cycle N:
  - Write hit: resp_valid in N+2.
  - Read hit: N+T_CL+1.
  - Closed bank: add T_RCD.
  - Conflict: add T_RP+T_RCD.
- Back-to-back: req_ready is high again in the cycle after RESP. There is no overlap between requests.
- Strobe exclusivity: dram_bank_rw and dram_buffer_rw are never high in the same cycle.
- Refresh counter:
  - Free-running; wraps at T_REFI-1 and sets refresh_pending on the wrap.
  - Pending stays set until serviced. A further wrap while pending has no extra effect.
- Refresh service:
  - In IDLE, pending has priority over req_valid in the same cycle (ready already 0).
  - REFRESH lasts T_RFC cycles, strobes low, refresh_busy=1.
  - On entry, all banks are closed and pending is cleared.
  - Requests never interrupt REFRESH, and refresh never interrupts a request; it waits for IDLE.
- Address/data outputs hold their last values when idle. The bench checks them only while a strobe is high.

Decomposition:
- Package dram_ctrl_pkg:
  - state enum.
  - default timing constants.
  - width localparams derived from bank/row/col counts.
- One sub-module, dram_open_row_table:
  - Per-bank valid bit + row register.
  - Lookup outputs hit/conflict/closed for a given bank/row.
  - Ports for set, clear-one and clear-all; async reset clears it.

Test Plan:
- Reset with rst_b low, then released → all outputs 0, req_ready=1, no strobes for 10 idle cycles.
- Write bank 3 row 5 col 2 data 1 (bank closed), accepted cycle N → 2 ACTIVATE cycles; dram_bank_rw=1 only in N+3 with bank_id 3, rowid 5, colid 2, wdata 1, wdata_oe 1; resp_valid in N+4.
- Read bank 3 row 5 col 2 (hit), array returns 1 → dram_buffer_rw high N+1..N+2, no activate, resp_valid N+3 with resp_rdata 1.
- Read bank 3 row 9 col 0 (conflict), array returns 0 → 2 PRECHARGE + 2 ACTIVATE cycles, buffer_rw N+5..N+6, resp_valid N+7 rdata 0; a subsequent bank 3 row 9 access is a hit.
- T_REFI=32, req_valid held high continuously → at the wrap, req_ready=0 and 4 refresh_busy cycles with no strobes; the next bank 3 row 9 access takes the closed-bank path (T_RCD added).
- rst_b pulsed low during READ → outputs go to 0 immediately; no resp_valid after release; the next access to bank 3 takes the closed path.
